// File: rtl/cen_gen_multi.sv
// -----------------------------------------------------------------------------
// cen_gen_multi
// Multi-channel fractional clock-enable generator running on one master clock.
// Each channel runs a modulo accumulator that adds `num` every cycle and wraps
// at `den`. Every wrap produces a one-cycle enable, so the average rate is
// num/den of refclk. An optional companion accumulator per channel produces a
// phase-lagged copy of the same train. `locked` rises once the configuration
// has stayed unchanged for LOCK_CYCLES cycles.
//
// Optional feature macro: CEN_GEN_MULTI_PHASE_EN
//   defined   : companion accumulators and phase registers are built, and
//               cen_ph is live.
//   undefined : cen_ph is tied to 0, cfg_phase is ignored (including in write
//               validation), and the main accumulator reloads to 0 on a write.
//
// Parameters:
//   CHANNELS    number of enable channels (1..16)
//   ACC_W       accumulator / numerator / denominator / phase width
//   LOCK_CYCLES cycles from reset release or accepted write until locked = 1
//   DEF_NUM     numerator loaded into every channel at reset
//   DEF_DEN     denominator loaded into every channel at reset
//
// Ports:
//   refclk     master clock, rising edge
//   rst        asynchronous active-high reset
//   cfg_wr     single-cycle configuration write strobe
//   cfg_ch     target channel of the write
//   cfg_num    enable numerator (accumulator step)
//   cfg_den    enable denominator (accumulator modulus)
//   cfg_phase  companion lag in accumulator units
//   cfg_err    one-cycle pulse in the cycle after a rejected write
//   cen        main enable, one bit per channel
//   cen_ph     companion (phase-lagged) enable, one bit per channel
//   locked     enable trains have been stable for LOCK_CYCLES cycles
//
// Write strobe semantics: there is no backpressure. cfg_wr is a one-cycle
// strobe sampled on a rising refclk edge together with cfg_ch/num/den/phase.
// A valid write takes effect on that edge; an invalid one changes nothing and
// is answered by cfg_err in the following cycle. Writes while rst is high are
// ignored.
// -----------------------------------------------------------------------------
module cen_gen_multi #(
  parameter int CHANNELS    = 4,
  parameter int ACC_W       = 16,
  parameter int LOCK_CYCLES = 256,
  parameter int DEF_NUM     = 1,
  parameter int DEF_DEN     = 8
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                cfg_wr,
  input  logic [3:0]          cfg_ch,
  input  logic [ACC_W-1:0]    cfg_num,
  input  logic [ACC_W-1:0]    cfg_den,
  input  logic [ACC_W-1:0]    cfg_phase,
  output logic                cfg_err,
  output logic [CHANNELS-1:0] cen,
  output logic [CHANNELS-1:0] cen_ph,
  output logic                locked
);

  localparam int               LCW      = $clog2(LOCK_CYCLES + 1);
  localparam logic [LCW-1:0]   LOCK_MAX = LCW'(LOCK_CYCLES);
  localparam logic [ACC_W-1:0] NUM_RST  = ACC_W'(DEF_NUM);
  localparam logic [ACC_W-1:0] DEN_RST  = ACC_W'(DEF_DEN);

  logic             w_ch_ok;
  logic             w_ratio_ok;
  logic             w_phase_ok;
  logic             w_wr_ok;
  logic [ACC_W-1:0] w_reload;
  logic             r_err;
  logic [LCW-1:0]   r_lock_cnt;

  // Write validation. num <= den keeps at most one wrap per cycle, and
  // phase < den keeps the reloaded accumulator inside its modulus.
  assign w_ch_ok    = (int'(cfg_ch) < CHANNELS);
  assign w_ratio_ok = (cfg_den != '0) && (cfg_num != '0) && (cfg_num <= cfg_den);
`ifdef CEN_GEN_MULTI_PHASE_EN
  assign w_phase_ok = (cfg_phase < cfg_den);
  assign w_reload   = cfg_phase;
`else
  logic w_cfg_phase_unused;
  assign w_phase_ok         = 1'b1;
  assign w_reload           = '0;
  assign w_cfg_phase_unused = ^cfg_phase;
`endif
  assign w_wr_ok = cfg_wr && w_ch_ok && w_ratio_ok && w_phase_ok;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [ACC_W-1:0] r_num;
    logic [ACC_W-1:0] r_den;
    logic [ACC_W-1:0] r_acc_m;
    logic             r_cen;
    logic             w_sel;
    logic [ACC_W:0]   w_sum_m;

    assign w_sel   = w_wr_ok && (int'(cfg_ch) == g);
    // One extra bit so acc + num cannot overflow before the compare.
    assign w_sum_m = {1'b0, r_acc_m} + {1'b0, r_num};

    always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
        r_num   <= NUM_RST;
        r_den   <= DEN_RST;
        r_acc_m <= '0;
        r_cen   <= 1'b0;
      end else if (w_sel) begin
        r_num   <= cfg_num;
        r_den   <= cfg_den;
        r_acc_m <= w_reload;
        r_cen   <= 1'b0;
      end else if (w_sum_m >= {1'b0, r_den}) begin
        // sum - den < den fits in ACC_W bits, so the low bits are exact.
        r_acc_m <= w_sum_m[ACC_W-1:0] - r_den;
        r_cen   <= 1'b1;
      end else begin
        r_acc_m <= w_sum_m[ACC_W-1:0];
        r_cen   <= 1'b0;
      end
    end

    assign cen[g] = r_cen;

`ifdef CEN_GEN_MULTI_PHASE_EN
    logic [ACC_W-1:0] r_phase;
    logic [ACC_W-1:0] r_acc_c;
    logic             r_cen_ph;
    logic [ACC_W:0]   w_sum_c;
    logic             w_phase_unused;

    assign w_sum_c = {1'b0, r_acc_c} + {1'b0, r_num};

    // Companion runs the same ratio from 0 while main starts at phase, so the
    // companion trails main by phase/num cycles.
    always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
        r_phase  <= '0;
        r_acc_c  <= '0;
        r_cen_ph <= 1'b0;
      end else if (w_sel) begin
        r_phase  <= cfg_phase;
        r_acc_c  <= '0;
        r_cen_ph <= 1'b0;
      end else if (w_sum_c >= {1'b0, r_den}) begin
        r_acc_c  <= w_sum_c[ACC_W-1:0] - r_den;
        r_cen_ph <= 1'b1;
      end else begin
        r_acc_c  <= w_sum_c[ACC_W-1:0];
        r_cen_ph <= 1'b0;
      end
    end

    // The stored phase only matters at reload time; it is kept as the
    // channel's configured value.
    assign w_phase_unused = ^r_phase;
    assign cen_ph[g]      = r_cen_ph;
`else
    assign cen_ph[g] = 1'b0;
`endif
  end

  // Lock counter: cleared by any accepted write, saturates at LOCK_CYCLES.
  // A write on the saturating edge clears it, so the write wins.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_lock_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= cfg_wr && !w_wr_ok;
      if (w_wr_ok) begin
        r_lock_cnt <= '0;
      end else if (r_lock_cnt != LOCK_MAX) begin
        r_lock_cnt <= r_lock_cnt + LCW'(1);
      end
    end
  end

  assign locked  = (r_lock_cnt == LOCK_MAX);
  assign cfg_err = r_err;

endmodule

// File: tb/tb_cen_gen_multi.sv
// -----------------------------------------------------------------------------
// tb_cen_gen_multi
// Self-checking bench for cen_gen_multi with default parameters. The reference
// model tracks, per channel, the configured ratio, the starting accumulator
// value and the number of edges since the last reload; an enable is expected
// on edge k whenever floor((a0 + k*num)/den) steps up. Lock is modelled as
// "edges since last accepted write or reset >= LOCK_CYCLES".
// -----------------------------------------------------------------------------
module tb_cen_gen_multi;
  localparam int CH   = 4;
  localparam int AW   = 16;
  localparam int LOCK = 256;
`ifdef CEN_GEN_MULTI_PHASE_EN
  localparam bit PH_EN = 1'b1;
`else
  localparam bit PH_EN = 1'b0;
`endif

  // clock / reset / DUT
  logic           refclk = 1'b0;
  logic           rst;
  logic           cfg_wr;
  logic [3:0]     cfg_ch;
  logic [AW-1:0]  cfg_num;
  logic [AW-1:0]  cfg_den;
  logic [AW-1:0]  cfg_phase;
  logic           cfg_err;
  logic [CH-1:0]  cen;
  logic [CH-1:0]  cen_ph;
  logic           locked;

  int checks = 0;
  int errors = 0;

  always #5 refclk = ~refclk;

  cen_gen_multi #(
    .CHANNELS(CH), .ACC_W(AW), .LOCK_CYCLES(LOCK), .DEF_NUM(1), .DEF_DEN(8)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_wr   (cfg_wr),
    .cfg_ch   (cfg_ch),
    .cfg_num  (cfg_num),
    .cfg_den  (cfg_den),
    .cfg_phase(cfg_phase),
    .cfg_err  (cfg_err),
    .cen      (cen),
    .cen_ph   (cen_ph),
    .locked   (locked)
  );

  // reference model
  int m_num [CH];
  int m_den [CH];
  int m_ph  [CH];
  int m_k   [CH];
  int m_lock;
  bit m_err;

  logic [CH-1:0] exp_q[$];

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_num[i] = 1;
      m_den[i] = 8;
      m_ph[i]  = 0;
      m_k[i]   = 0;
    end
    m_lock = 0;
    m_err  = 1'b0;
  endtask

  function automatic bit wr_valid();
    bit ok;
    ok = (int'(cfg_ch) < CH) && (cfg_den != 0) && (cfg_num != 0) && (cfg_num <= cfg_den);
    if (PH_EN) ok = ok && (cfg_phase < cfg_den);
    return ok;
  endfunction

  function automatic bit fires(int a0, int n, int d, int k);
    longint hi, lo;
    if (k < 1) return 1'b0;
    hi = (longint'(a0) + longint'(k) * n) / d;
    lo = (longint'(a0) + longint'(k - 1) * n) / d;
    return hi != lo;
  endfunction

  // {cen, cen_ph, locked, cfg_err} as the model expects them now
  function automatic logic [2*CH+1:0] exp_outs();
    logic [CH-1:0] c, p;
    for (int i = 0; i < CH; i++) begin
      c[i] = fires(m_ph[i], m_num[i], m_den[i], m_k[i]);
      p[i] = PH_EN && fires(0, m_num[i], m_den[i], m_k[i]);
    end
    return {c, p, (m_lock >= LOCK), m_err};
  endfunction

  // driver: one rising edge, model follows the inputs the DUT sampled
  task automatic tick();
    bit ok, valid;
    @(posedge refclk);
    if (rst) begin
      model_reset();
    end else begin
      valid = wr_valid();
      ok    = cfg_wr && valid;
      m_err = cfg_wr && !valid;
      for (int i = 0; i < CH; i++) m_k[i]++;
      if (ok) begin
        m_num[cfg_ch] = int'(cfg_num);
        m_den[cfg_ch] = int'(cfg_den);
        m_ph[cfg_ch]  = PH_EN ? int'(cfg_phase) : 0;
        m_k[cfg_ch]   = 0;
        m_lock        = 0;
      end else if (m_lock < LOCK) begin
        m_lock++;
      end
    end
    #1;
  endtask

  task automatic drive_wr(int ch, int num, int den, int ph);
    cfg_wr    = 1'b1;
    cfg_ch    = 4'(ch);
    cfg_num   = AW'(num);
    cfg_den   = AW'(den);
    cfg_phase = AW'(ph);
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1; cfg_wr = 1'b0; cfg_ch = '0; cfg_num = '0; cfg_den = '0; cfg_phase = '0;
    model_reset();
    #2;
    checks++;
    if ({cen, cen_ph, locked, cfg_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=0", {cen, cen_ph, locked, cfg_err});
    end
    tick(); tick();
    checks++;
    if ({cen, cen_ph, locked, cfg_err} !== '0) begin
      errors++;
      $display("FAIL reset_held got=%b exp=0", {cen, cen_ph, locked, cfg_err});
    end
    rst = 1'b0;
  endtask

  task automatic test_default_run();
    for (int i = 0; i < 300; i++) begin
      tick();
      checks++;
      if ({cen, cen_ph, locked, cfg_err} !== exp_outs()) begin
        errors++;
        $display("FAIL default_run cyc=%0d got=%b exp=%b", i + 1, {cen, cen_ph, locked, cfg_err}, exp_outs());
      end
      if (i == 7) begin
        checks++;
        if (cen !== '1) begin
          errors++;
          $display("FAIL first_cen_at_8 got=%b exp=1111", cen);
        end
      end
    end
  endtask

  task automatic test_phase_write();
    drive_wr(1, 1, 8, 4);
    tick();
    cfg_wr = 1'b0;
    for (int i = 0; i < 270; i++) begin
      checks++;
      if ({cen, cen_ph, locked, cfg_err} !== exp_outs()) begin
        errors++;
        $display("FAIL phase_write cyc=+%0d got=%b exp=%b", i, {cen, cen_ph, locked, cfg_err}, exp_outs());
      end
      tick();
    end
  endtask

  task automatic test_ratio3();
    logic [CH-1:0] obs [64];
    logic [CH-1:0] e, m;
    int cnt, last, maxgap;
    drive_wr(2, 3, 8, 0);
    tick();
    cfg_wr = 1'b0;
    for (int i = 0; i < 64; i++) begin
      tick();
      m = exp_outs() >> (CH + 2);
      exp_q.push_back(m);
      obs[i] = cen;
    end
    for (int i = 0; i < 64; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs[i] !== e) begin
        errors++;
        $display("FAIL ratio3_cen cyc=+%0d got=%b exp=%b", i + 1, obs[i], e);
      end
    end
    for (int w = 0; w < 8; w++) begin
      cnt = 0;
      for (int j = 0; j < 8; j++) cnt += int'(obs[w*8+j][2]);
      checks++;
      if (cnt != 3) begin
        errors++;
        $display("FAIL ratio3_window w=%0d got=%0d exp=3", w, cnt);
      end
    end
    last = -1; maxgap = 0;
    for (int i = 0; i < 64; i++) begin
      if (obs[i][2]) begin
        if (last >= 0 && i - last > maxgap) maxgap = i - last;
        last = i;
      end
    end
    checks++;
    if (maxgap < 1 || maxgap > 3) begin
      errors++;
      $display("FAIL ratio3_gap got=%0d exp=1..3", maxgap);
    end
  endtask

  task automatic test_lock_race();
    drive_wr(0, 1, 8, 0);
    tick();
    cfg_wr = 1'b0;
    for (int i = 0; i < LOCK - 1; i++) tick();
    // counter now one short of saturation; a write on this edge must win
    drive_wr(3, 2, 5, 1);
    tick();
    cfg_wr = 1'b0;
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL lock_race got=%b exp=0", locked);
    end
    for (int i = 0; i < 262; i++) begin
      checks++;
      if ({cen, cen_ph, locked, cfg_err} !== exp_outs()) begin
        errors++;
        $display("FAIL lock_race_run cyc=+%0d got=%b exp=%b", i, {cen, cen_ph, locked, cfg_err}, exp_outs());
      end
      tick();
    end
  endtask

  task automatic test_rejects();
    int tab [5][4] = '{'{0, 1, 0, 0}, '{0, 9, 8, 0}, '{1, 1, 8, 8}, '{5, 1, 8, 0}, '{2, 0, 8, 0}};
    for (int t = 0; t < 5; t++) begin
      drive_wr(tab[t][0], tab[t][1], tab[t][2], tab[t][3]);
      tick();
      cfg_wr = 1'b0;
      for (int c = 0; c < 3; c++) begin
        checks++;
        if ({cen, cen_ph, locked, cfg_err} !== exp_outs()) begin
          errors++;
          $display("FAIL reject t=%0d cyc=+%0d got=%b exp=%b", t, c, {cen, cen_ph, locked, cfg_err}, exp_outs());
        end
        tick();
      end
    end
  endtask

  task automatic test_random_writes();
    int ch, den, num, ph, n, kind;
    for (int it = 0; it < 40; it++) begin
      ch  = $urandom_range(0, CH - 1);
      den = $urandom_range(1, 20);
      num = $urandom_range(1, den);
      ph  = $urandom_range(0, den - 1);
      if ($urandom_range(0, 9) == 0) num = den;
      if ($urandom_range(0, 6) == 0) begin
        kind = $urandom_range(0, 3);
        case (kind)
          0: den = 0;
          1: num = den + 1;
          2: ch = $urandom_range(CH, 15);
          default: ph = den + $urandom_range(0, 5);
        endcase
      end
      drive_wr(ch, num, den, ph);
      tick();
      cfg_wr = 1'b0;
      n = $urandom_range(1, 25);
      for (int c = 0; c <= n; c++) begin
        checks++;
        if ({cen, cen_ph, locked, cfg_err} !== exp_outs()) begin
          errors++;
          $display("FAIL random it=%0d cyc=+%0d got=%b exp=%b", it, c, {cen, cen_ph, locked, cfg_err}, exp_outs());
        end
        tick();
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1;
    drive_wr(0, 5, 7, 0);
    #1;
    model_reset();
    checks++;
    if ({cen, cen_ph, locked, cfg_err} !== '0) begin
      errors++;
      $display("FAIL midreset_async got=%b exp=0", {cen, cen_ph, locked, cfg_err});
    end
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0;
    cfg_wr = 1'b0;
    for (int i = 0; i < 270; i++) begin
      tick();
      checks++;
      if ({cen, cen_ph, locked, cfg_err} !== exp_outs()) begin
        errors++;
        $display("FAIL midreset_restart cyc=%0d got=%b exp=%b", i + 1, {cen, cen_ph, locked, cfg_err}, exp_outs());
      end
    end
  endtask

`ifndef CEN_GEN_MULTI_PHASE_EN
  task automatic test_no_phase();
    drive_wr(3, 1, 8, 20);
    tick();
    cfg_wr = 1'b0;
    checks++;
    if ({cfg_err, locked} !== 2'b00) begin
      errors++;
      $display("FAIL nophase_accept got=%b exp=00", {cfg_err, locked});
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (cen_ph !== '0 || {cen, cen_ph, locked, cfg_err} !== exp_outs()) begin
        errors++;
        $display("FAIL nophase_run cyc=+%0d got=%b exp=%b", i + 1, {cen, cen_ph, locked, cfg_err}, exp_outs());
      end
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_default_run();
    test_phase_write();
    test_ratio3();
    test_lock_race();
    test_rejects();
    test_random_writes();
    test_reset_midstream();
`ifndef CEN_GEN_MULTI_PHASE_EN
    test_no_phase();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cen_gen_multi.md
# cen_gen_multi

Parametrised multi-channel fractional clock-enable generator driven from one fast master clock. Each channel produces a main enable pulse train and an optional phase-lagged companion pulse train, with ratios programmable at run time. It replaces fixed divided and phase-shifted PLL outputs: the core runs on one PLL clock and consumes these enables. A `locked` flag is raised after a fixed settle interval so downstream logic can hold off until the enable trains are stable.

## Interface
Parameters:
- `CHANNELS`, 4 — number of independent enable channels (1..16).
- `ACC_W`, 16 — accumulator, numerator, denominator and phase width.
- `LOCK_CYCLES`, 256 — master cycles from reset release or accepted write to `locked`=1.
- `DEF_NUM`, 1 — numerator loaded into every channel at reset.
- `DEF_DEN`, 8 — denominator loaded into every channel at reset.

Ports:
- `refclk` in 1 — master clock; all logic is on its rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `cfg_wr` in 1 — single-cycle configuration write strobe.
- `cfg_ch` in 4 — target channel index.
- `cfg_num` in ACC_W — enable numerator (step).
- `cfg_den` in ACC_W — enable denominator (modulus).
- `cfg_phase` in ACC_W — companion lag, in accumulator units.
- `cfg_err` out 1 — one-cycle pulse when a write is rejected.
- `cen` out CHANNELS — main enable, one bit per channel.
- `cen_ph` out CHANNELS — companion (phase-lagged) enable.
- `locked` out 1 — enable trains are stable.

## Operation
- Per-channel registers: `num`, `den`, `phase`, main accumulator `acc_m`, companion accumulator `acc_c`.
- Reset values: `num`=DEF_NUM, `den`=DEF_DEN, `phase`=0, `acc_m`=0, `acc_c`=0. All outputs reset to 0.
- Each cycle, per accumulator:
  - Form `sum = acc + num` at ACC_W+1 bits.
  - If `sum >= den`: `acc <= sum - den`, and the enable bit is registered as 1.
  - Otherwise: `acc <= sum`, and the enable bit is registered as 0.
- Average rate is `num/den` of `refclk`. `num == den` gives a continuous enable.
- The companion accumulator starts at 0 and the main accumulator starts at `phase`. The companion therefore lags main by `phase/num` cycles in steady state.
- Write acceptance: a write is accepted when `cfg_ch < CHANNELS`, `cfg_den != 0`, `cfg_num != 0`, `cfg_num <= cfg_den` and `cfg_phase < cfg_den`.
- Accepted write:
  - Updates that channel's `num`, `den` and `phase`.
  - Reloads `acc_m = cfg_phase` and `acc_c = 0`.
  - Forces that channel's `cen` and `cen_ph` to 0 for the following cycle.
  - Deasserts `locked` and restarts the lock counter.
  - Other channels are unaffected.
- Rejected write: no state change; `cfg_err` = 1 for exactly one cycle.
- Lock counter:
  - Counts `refclk` cycles from reset release or from the last accepted write.
  - Saturates at LOCK_CYCLES.
  - `locked` = 1 while the counter is saturated.
- Assertion of `rst` mid-operation returns every register to its reset value immediately, with no dependence on `refclk`.

## Timing
- Enables are registered: an enable asserts during the cycle after the edge whose `sum` crossed `den`.
- Example: DEF_NUM=1, DEF_DEN=8, `phase`=0. The first `cen` is high after the 8th edge after reset release, then every 8 cycles.
- Write latency: the write is sampled on edge E. The new ratio is used from edge E+1. The forced-zero enables are visible in the cycle after E.
- `cfg_err` asserts in the cycle after the rejected write's edge.
- `locked` rises after LOCK_CYCLES edges with no accepted write. A write accepted in the same cycle that the counter saturates wins: `locked` stays 0.
- A simultaneous `cfg_wr` and `rst` is ignored.

## Configuration
- Macro: `CEN_GEN_MULTI_PHASE_EN`.
- Defined: companion accumulators are present and `cen_ph` operates as described.
- Undefined:
  - No companion accumulators or `phase` registers are built.
  - `cen_ph` is tied to 0.
  - `acc_m` reloads to 0 on write.
  - `cfg_phase` is ignored, including in write validation.

## Test plan
- Reset default, CHANNELS=4 → all `cen` pulse on cycles 8, 16, 24…; `locked` = 0 until cycle 256, then 1; `cen_ph` matches `cen` when phase=0.
- Write ch1 num=1 den=8 phase=4 → `cen[1]` at +4, +12, +20 after the write; `cen_ph[1]` at +8, +16 (lag 4); `locked` drops, then returns after 256 cycles.
- Write ch2 num=3 den=8 → exactly 3 `cen[2]` pulses in every 8-cycle window over 64 cycles, with no two-cycle gap longer than 3.
- Rejected writes (den=0; num=9 den=8; phase=8 den=8; cfg_ch=5) → `cfg_err` pulses once each; channel outputs and `locked` are unchanged.
- Assert `rst` for 3 cycles mid-stream → outputs 0 immediately; after release the sequence restarts exactly as from power-up.
- Macro undefined → `cen_ph` = 0 at all times; a write with phase=20 den=8 is accepted.
